key_debounce_multi: RTL and testbench
=====================================

Name: key_debounce_multi

Overview:
Parametrised successor to the single-counter key filter. Each of KEY_W active-low keys gets its own synchroniser, debounce counter and per-key state machine, so presses on different keys never share or restart each other's timing. Outputs give the debounced level plus one-cycle press, release, long-press and auto-repeat pulses. The block sits between the board keys and the UI/VGA control logic.

Parameters:
KEY_W, 4, number of independent key channels (>=1)
DELAY_TIME, 1_000_000, debounce window in clk cycles; input must be stable this long (>=2)
HOLD_TIME, 50_000_000, clk cycles in HELD before key_long fires (>=2)
REPEAT_TIME, 10_000_000, clk cycles between key_repeat pulses after key_long (>=2)
REPEAT_EN, 1, 1 enables key_repeat; 0 forces key_repeat to 0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_in  in  KEY_W  raw key inputs; low = pressed, idle high, asynchronous to clk
key_state  out  KEY_W  debounced level; 1 = pressed
key_down  out  KEY_W  one-cycle pulse on debounced press
key_up  out  KEY_W  one-cycle pulse on debounced release
key_long  out  KEY_W  one-cycle pulse when a key has been held HOLD_TIME
key_repeat  out  KEY_W  one-cycle pulse every REPEAT_TIME after key_long while the key stays held

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: every output is 0. All states are IDLE. All counters are 0. Synchroniser flops are set to all-ones (released).
- Synchroniser: 2 flops per bit (key_r0 -> key_r1). The FSM samples s = key_r1[i].
- Counter widths: derived with $clog2 of each time parameter. The debounce counter is per channel. The hold and repeat counters are per channel.
- Per-channel FSM:
  - IDLE: if s==0, go to FILT_DN and clear the debounce counter.
  - FILT_DN: if s==1, go to IDLE (bounce rejected, no pulse). Otherwise increment the counter. When counter==DELAY_TIME-1: go to HELD, set key_state=1, pulse key_down, clear the hold counter.
  - HELD: if s==1, go to FILT_UP and clear the debounce counter. Otherwise increment the hold counter, saturating at HOLD_TIME-1.
    - On the cycle the hold counter reaches HOLD_TIME-1, pulse key_long once and clear the repeat counter.
    - After that, if REPEAT_EN, the repeat counter wraps every REPEAT_TIME cycles and pulses key_repeat on each wrap (counter==REPEAT_TIME-1).
  - FILT_UP: if s==0, go back to HELD. No key_down is issued; the hold and repeat counters resume from their frozen values. Otherwise increment the counter. When counter==DELAY_TIME-1: go to IDLE, set key_state=0, pulse key_up.
- Latency: key_down[i] is high for exactly one cycle, starting DELAY_TIME+3 rising edges after the edge that first samples key_in[i] low, provided the input stays low. key_up has the same latency, measured from the first high sample.
- Pulse width: each of key_down, key_up, key_long and key_repeat is high for exactly 1 cycle per event. key_long fires at most once per press.
- Channel independence: channels are fully independent. Several bits of any output may pulse in the same cycle. A bounce on one channel has no effect on another.
- Bounce reset: a bounce during FILT_DN or FILT_UP restarts the full DELAY_TIME window on the next stable sample.
- Reset mid-operation: all pulses are cancelled at once and key_state drops to 0. A key still held when rst_n releases re-filters and produces key_down one DELAY_TIME window later. It produces no key_up before that.
- Combinational paths: none from key_in to any output.

Test Plan:
- Clean press, params DELAY_TIME=8, HOLD_TIME=32, REPEAT_TIME=16, REPEAT_EN=1: drive key_in[0] low and hold it. Required: key_down[0] is a single pulse 11 edges after the first low sample, and key_state[0] rises on the same cycle. key_long[0] pulses 32 cycles later. key_repeat[0] pulses every 16 cycles after that.
- Bounce rejection: key_in[1] toggles low/high with periods under 8 cycles for 100 cycles, then returns high. Required: no key_down[1] and no key_up[1]; key_state[1] stays 0.
- Release with glitch: hold key 2 until key_state[2]=1, then release with one 3-cycle low glitch inside the FILT_UP window. Required: no second key_down. key_up[2] pulses once, 11 edges after the last transition to high.
- Simultaneous keys: press keys 0 and 3 on the same cycle. Required: key_down=4'b1001 in one cycle. Then release key 3 only. Required: key_up=4'b1000, and key_state[0] stays 1.
- REPEAT_EN=0 long hold: hold key 0 for 200 cycles. Required: exactly one key_long pulse and key_repeat stays 0.
- Reset mid-hold: assert rst_n=0 while key_state[0]=1 and key_in[0] is low. Required: all outputs are 0 immediately. After deassert, key_down[0] pulses once 11 edges later, with no key_up pulse.

Source files
------------

// File: rtl/key_debounce_multi.sv
// Multi-channel active-low key filter: per-key synchroniser, debounce FSM, and
// registered press/release/long-press/auto-repeat pulses.
module key_debounce_multi #(
    parameter int KEY_W       = 4,
    parameter int DELAY_TIME  = 1_000_000,
    parameter int HOLD_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 10_000_000,
    parameter int REPEAT_EN   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_down,
    output logic [KEY_W-1:0] key_up,
    output logic [KEY_W-1:0] key_long,
    output logic [KEY_W-1:0] key_repeat
);

    localparam int DW = $clog2(DELAY_TIME);
    localparam int HW = $clog2(HOLD_TIME);
    localparam int RW = $clog2(REPEAT_TIME);
    localparam logic [DW-1:0] DLY_LAST  = DW'(DELAY_TIME - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TIME - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TIME - 1);

    typedef enum logic [1:0] {IDLE, FILT_DN, HELD, FILT_UP} state_t;

    logic [KEY_W-1:0] key_r0, key_r1;
    logic [KEY_W-1:0] down_ev, up_ev, long_ev, rep_ev;
    logic [KEY_W-1:0] down_p1, up_p1, long_p1, rep_p1, state_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r0 <= '1;
            key_r1 <= '1;
        end else begin
            key_r0 <= key_in;
            key_r1 <= key_r0;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_ch
        state_t        state, state_nxt;
        logic [DW-1:0] dcnt, dcnt_nxt;
        logic [HW-1:0] hcnt, hcnt_nxt;
        logic [RW-1:0] rcnt, rcnt_nxt;
        logic          long_done, long_done_nxt;
        logic          dn, up, lg, rp;
        logic          s;

        assign s = key_r1[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                dcnt      <= '0;
                hcnt      <= '0;
                rcnt      <= '0;
                long_done <= 1'b0;
            end else begin
                state     <= state_nxt;
                dcnt      <= dcnt_nxt;
                hcnt      <= hcnt_nxt;
                rcnt      <= rcnt_nxt;
                long_done <= long_done_nxt;
            end
        end

        // Hold and repeat counters freeze in FILT_UP so a release glitch resumes timing.
        always_comb begin
            state_nxt     = state;
            dcnt_nxt      = dcnt;
            hcnt_nxt      = hcnt;
            rcnt_nxt      = rcnt;
            long_done_nxt = long_done;
            dn            = 1'b0;
            up            = 1'b0;
            lg            = 1'b0;
            rp            = 1'b0;
            case (state)
                IDLE: begin
                    if (!s) begin
                        state_nxt = FILT_DN;
                        dcnt_nxt  = '0;
                    end
                end
                FILT_DN: begin
                    if (s) begin
                        state_nxt = IDLE;
                    end else if (dcnt == DLY_LAST) begin
                        state_nxt     = HELD;
                        dn            = 1'b1;
                        hcnt_nxt      = '0;
                        rcnt_nxt      = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        dcnt_nxt = dcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (s) begin
                        state_nxt = FILT_UP;
                        dcnt_nxt  = '0;
                    end else if (!long_done) begin
                        if (hcnt == HOLD_LAST) begin
                            lg            = 1'b1;
                            long_done_nxt = 1'b1;
                            rcnt_nxt      = '0;
                        end else begin
                            hcnt_nxt = hcnt + 1'b1;
                        end
                    end else if (rcnt == REP_LAST) begin
                        rp       = (REPEAT_EN != 0);
                        rcnt_nxt = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                FILT_UP: begin
                    if (!s) begin
                        state_nxt = HELD;
                    end else if (dcnt == DLY_LAST) begin
                        state_nxt = IDLE;
                        up        = 1'b1;
                    end else begin
                        dcnt_nxt = dcnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign down_ev[i] = dn;
        assign up_ev[i]   = up;
        assign long_ev[i] = lg;
        assign rep_ev[i]  = rp;
    end

    // Stage p1: event capture; then output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_p1  <= '0;
            up_p1    <= '0;
            long_p1  <= '0;
            rep_p1   <= '0;
            state_p1 <= '0;
        end else begin
            down_p1  <= down_ev;
            up_p1    <= up_ev;
            long_p1  <= long_ev;
            rep_p1   <= rep_ev;
            state_p1 <= (state_p1 | down_ev) & ~up_ev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state  <= '0;
            key_down   <= '0;
            key_up     <= '0;
            key_long   <= '0;
            key_repeat <= '0;
        end else begin
            key_state  <= state_p1;
            key_down   <= down_p1;
            key_up     <= up_p1;
            key_long   <= long_p1;
            key_repeat <= rep_p1;
        end
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: one instance with auto-repeat, one without.
module tb_key_debounce_multi;

    localparam int KW = 4;
    localparam int DT = 8;
    localparam int HT = 32;
    localparam int RT = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] key_a = '1;
    logic [KW-1:0] key_b = '1;
    logic [KW-1:0] st_a, dn_a, up_a, lg_a, rp_a;
    logic [KW-1:0] st_b, dn_b, up_b, lg_b, rp_b;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    int dn_cnt[KW]  = '{default: 0};
    int dn_last[KW] = '{default: -1};
    int up_cnt[KW]  = '{default: 0};
    int up_last[KW] = '{default: -1};
    int lg_cnt[KW]  = '{default: 0};
    int lg_last[KW] = '{default: -1};
    int rp_cnt[KW]  = '{default: 0};
    int rp_last[KW] = '{default: -1};
    int sr_cnt[KW]  = '{default: 0};
    int sr_last[KW] = '{default: -1};
    logic [KW-1:0] st_prev = '0;
    int lgb_cnt = 0;
    int rpb_cnt = 0;
    int dnb_cnt = 0;

    key_debounce_multi #(
        .KEY_W(KW), .DELAY_TIME(DT), .HOLD_TIME(HT), .REPEAT_TIME(RT), .REPEAT_EN(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_a),
        .key_state(st_a), .key_down(dn_a), .key_up(up_a),
        .key_long(lg_a), .key_repeat(rp_a)
    );

    key_debounce_multi #(
        .KEY_W(KW), .DELAY_TIME(DT), .HOLD_TIME(HT), .REPEAT_TIME(RT), .REPEAT_EN(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_b),
        .key_state(st_b), .key_down(dn_b), .key_up(up_b),
        .key_long(lg_b), .key_repeat(rp_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < KW; i++) begin
            if (dn_a[i]) begin dn_cnt[i]++; dn_last[i] = cyc; end
            if (up_a[i]) begin up_cnt[i]++; up_last[i] = cyc; end
            if (lg_a[i]) begin lg_cnt[i]++; lg_last[i] = cyc; end
            if (rp_a[i]) begin rp_cnt[i]++; rp_last[i] = cyc; end
            if (st_a[i] && !st_prev[i]) begin sr_cnt[i]++; sr_last[i] = cyc; end
        end
        st_prev = st_a;
        if (lg_b[0]) lgb_cnt++;
        if (|rp_b) rpb_cnt++;
        if (dn_b[0]) dnb_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int t;
    int s_dn, s_up, s_lg, s_rp, s_sr, s_b_lg, s_b_rp, s_b_dn;

    initial begin
        rst_n = 1'b0;
        tick(3);
        chk("rst_state", int'(st_a), 0);
        chk("rst_down", int'(dn_a), 0);
        chk("rst_up", int'(up_a), 0);
        chk("rst_long", int'(lg_a), 0);
        chk("rst_repeat", int'(rp_a), 0);
        chk("rst_b_state", int'(st_b), 0);
        chk("rst_b_up", int'(up_b), 0);
        rst_n = 1'b1;
        tick(3);

        // clean press on key 0
        s_dn = dn_cnt[0]; s_lg = lg_cnt[0]; s_rp = rp_cnt[0];
        t = cyc;
        key_a[0] = 1'b0;
        tick(11);
        chk("press_early", int'(dn_a[0]), 0);
        tick(84);
        chk("press_cnt", dn_cnt[0] - s_dn, 1);
        chk("press_time", dn_last[0], t + DT + 4);
        chk("press_state_time", sr_last[0], t + DT + 4);
        chk("long_cnt", lg_cnt[0] - s_lg, 1);
        chk("long_time", lg_last[0], t + DT + 4 + HT);
        chk("repeat_cnt", rp_cnt[0] - s_rp, 3);
        chk("repeat_time", rp_last[0], t + DT + 4 + HT + 3 * RT);
        t = cyc;
        key_a[0] = 1'b1;
        tick(11);
        chk("release_early", int'(up_a[0]), 0);
        tick(1);
        chk("release_pulse", int'(up_a[0]), 1);
        chk("release_state", int'(st_a[0]), 0);
        tick(1);
        chk("release_width", int'(up_a[0]), 0);

        // bounce on key 1: low 4 / high 3 cycles
        s_dn = dn_cnt[1]; s_up = up_cnt[1]; s_sr = sr_cnt[1];
        for (int k = 0; k < 100; k++) begin
            key_a[1] = ((k % 7) < 4) ? 1'b0 : 1'b1;
            tick(1);
        end
        key_a[1] = 1'b1;
        tick(20);
        chk("bounce_down", dn_cnt[1] - s_dn, 0);
        chk("bounce_up", up_cnt[1] - s_up, 0);
        chk("bounce_state", sr_cnt[1] - s_sr, 0);

        // key 2 release with a 3-cycle low glitch
        key_a[2] = 1'b0;
        tick(14);
        chk("k2_state", int'(st_a[2]), 1);
        s_dn = dn_cnt[2]; s_up = up_cnt[2];
        key_a[2] = 1'b1;
        tick(4);
        key_a[2] = 1'b0;
        tick(3);
        t = cyc;
        key_a[2] = 1'b1;
        tick(20);
        chk("glitch_down", dn_cnt[2] - s_dn, 0);
        chk("glitch_up_cnt", up_cnt[2] - s_up, 1);
        chk("glitch_up_time", up_last[2], t + DT + 4);

        // simultaneous keys 0 and 3
        key_a[0] = 1'b0;
        key_a[3] = 1'b0;
        tick(11);
        chk("simul_early", int'(dn_a), 0);
        tick(1);
        chk("simul_down", int'(dn_a), 4'b1001);
        chk("simul_state", int'(st_a), 4'b1001);
        tick(5);
        key_a[3] = 1'b1;
        tick(11);
        chk("k3_up_early", int'(up_a), 0);
        tick(1);
        chk("k3_up", int'(up_a), 4'b1000);
        chk("k3_state", int'(st_a), 4'b0001);

        // reset while key 0 held
        tick(5);
        s_up = up_cnt[0]; s_dn = dn_cnt[0];
        rst_n = 1'b0;
        #1;
        chk("midrst_state", int'(st_a), 0);
        chk("midrst_pulses", int'(dn_a | up_a | lg_a | rp_a), 0);
        tick(2);
        rst_n = 1'b1;
        t = cyc;
        tick(11);
        chk("rerun_early", int'(dn_a[0]), 0);
        tick(1);
        chk("rerun_down", int'(dn_a[0]), 1);
        chk("rerun_state", int'(st_a[0]), 1);
        tick(2);
        chk("rerun_down_cnt", dn_cnt[0] - s_dn, 1);
        chk("rerun_no_up", up_cnt[0] - s_up, 0);
        key_a[0] = 1'b1;
        tick(15);

        // long hold with auto-repeat disabled
        s_b_lg = lgb_cnt; s_b_rp = rpb_cnt; s_b_dn = dnb_cnt;
        key_b[0] = 1'b0;
        tick(200);
        chk("norep_down", dnb_cnt - s_b_dn, 1);
        chk("norep_long", lgb_cnt - s_b_lg, 1);
        chk("norep_repeat", rpb_cnt - s_b_rp, 0);
        key_b[0] = 1'b1;
        tick(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
